// File: rtl/prco_decode_stage_if.sv
// Handshake and bundle signals between fetch, the decode stage and execute.
// The master side (fetch/execute) drives valid, instruction and out-ready.
// The slave side (the decode stage) returns in-ready and the queued bundle.
interface prco_decode_stage_if #(
  parameter int DATA_W = 16
);
  // Fetch side
  logic              i_in_valid;
  logic [15:0]       i_instr;
  logic              q_in_ready;

  // Execute side
  logic              q_out_valid;
  logic              i_out_ready;
  logic [4:0]        q_op;
  logic [2:0]        q_seld;
  logic [2:0]        q_sela;
  logic [DATA_W-1:0] q_imm;
  logic [DATA_W-1:0] q_simm;
  logic              q_reg_we;
  logic              q_sr_we;
  logic              q_req_alu;
  logic              q_req_ram;
  logic              q_req_ram_we;
  logic              q_illegal;
  logic [7:0]        q_illegal_cnt;

  modport master (
    output i_in_valid, i_instr, i_out_ready,
    input  q_in_ready, q_out_valid, q_op, q_seld, q_sela, q_imm, q_simm,
           q_reg_we, q_sr_we, q_req_alu, q_req_ram, q_req_ram_we,
           q_illegal, q_illegal_cnt
  );

  modport slave (
    input  i_in_valid, i_instr, i_out_ready,
    output q_in_ready, q_out_valid, q_op, q_seld, q_sela, q_imm, q_simm,
           q_reg_we, q_sr_we, q_req_alu, q_req_ram, q_req_ram_we,
           q_illegal, q_illegal_cnt
  );
endinterface

// File: rtl/prco_decode_stage.sv
// PRCO buffered decode stage: decodes 16-bit instructions into control
// bundles, queues them in a DEPTH-entry FIFO for execute, interlocks
// instructions that read the destination of a recently accepted LW, and
// keeps a saturating count of illegal opcodes.
module prco_decode_stage #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 2,
  parameter int HAZ_BUBBLES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  prco_decode_stage_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_MOVI = 5'h01;
  localparam logic [4:0] OP_MOV  = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_ADDI = 5'h04;
  localparam logic [4:0] OP_OR   = 5'h05;
  localparam logic [4:0] OP_XOR  = 5'h06;
  localparam logic [4:0] OP_AND  = 5'h07;
  localparam logic [4:0] OP_CMP  = 5'h08;
  localparam logic [4:0] OP_LW   = 5'h09;
  localparam logic [4:0] OP_SW   = 5'h0A;

  typedef struct packed {
    logic [4:0]        op;
    logic [2:0]        seld;
    logic [2:0]        sela;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] simm;
    logic              reg_we;
    logic              sr_we;
    logic              req_alu;
    logic              req_ram;
    logic              req_ram_we;
    logic              illegal;
  } bundle_t;

  bundle_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_haz_cnt;
  logic [2:0]       r_haz_reg;
  logic [7:0]       r_illegal_cnt;

  bundle_t w_dec;
  bundle_t w_head;
  logic    w_rd_seld;
  logic    w_rd_sela;
  logic    w_hold;
  logic    w_ready;
  logic    w_push;
  logic    w_pop;

  // Decode the presented instruction into a bundle and its source-register usage.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_dec           = '0;
    w_dec.op        = bus.i_instr[15:11];
    w_dec.seld      = bus.i_instr[10:8];
    w_dec.sela      = bus.i_instr[7:5];
    w_dec.imm       = {{(DATA_W-8){1'b0}}, bus.i_instr[7:0]};
    w_dec.simm      = {{(DATA_W-5){bus.i_instr[4]}}, bus.i_instr[4:0]};
    w_rd_seld       = 1'b0;
    w_rd_sela       = 1'b0;
    case (bus.i_instr[15:11])
      OP_NOP: begin
      end
      OP_MOVI: begin
        w_dec.reg_we  = 1'b1;
        w_dec.req_alu = 1'b1;
      end
      OP_MOV: begin
        w_dec.reg_we  = 1'b1;
        w_dec.req_alu = 1'b1;
        w_rd_sela     = 1'b1;
      end
      OP_ADD, OP_OR, OP_XOR, OP_AND: begin
        w_dec.reg_we  = 1'b1;
        w_dec.req_alu = 1'b1;
        w_rd_seld     = 1'b1;
        w_rd_sela     = 1'b1;
      end
      OP_ADDI: begin
        w_dec.reg_we  = 1'b1;
        w_dec.req_alu = 1'b1;
        w_rd_seld     = 1'b1;
      end
      OP_CMP: begin
        w_dec.sr_we   = 1'b1;
        w_dec.req_alu = 1'b1;
        w_rd_seld     = 1'b1;
        w_rd_sela     = 1'b1;
      end
      OP_LW: begin
        w_dec.reg_we  = 1'b1;
        w_dec.req_alu = 1'b1;
        w_dec.req_ram = 1'b1;
        w_rd_sela     = 1'b1;
      end
      OP_SW: begin
        w_dec.req_alu    = 1'b1;
        w_dec.req_ram    = 1'b1;
        w_dec.req_ram_we = 1'b1;
        w_rd_seld        = 1'b1;
        w_rd_sela        = 1'b1;
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
  end

  // Stall a presented instruction that reads the register an LW is still loading.
  assign w_hold = (r_haz_cnt != 2'd0) & bus.i_in_valid &
                  ((w_rd_seld & (w_dec.seld == r_haz_reg)) |
                   (w_rd_sela & (w_dec.sela == r_haz_reg)));

  assign w_ready = ~i_reset & ~i_flush & (r_count < CNT_W'(DEPTH)) & ~w_hold;
  assign w_push  = bus.i_in_valid & w_ready;
  assign w_pop   = (r_count != '0) & bus.i_out_ready;

  // FIFO storage, pointers and occupancy; flush empties without touching storage.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: storage is reset too, so the head reads all-zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Load-use tracker: an accepted LW arms it, then it counts down every cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_haz_cnt <= 2'd0;
      r_haz_reg <= 3'd0;
    end else if (i_flush) begin
      r_haz_cnt <= 2'd0;
    end else if (w_push && (w_dec.op == OP_LW)) begin
      r_haz_cnt <= 2'(HAZ_BUBBLES);
      r_haz_reg <= w_dec.seld;
    end else if (r_haz_cnt != 2'd0) begin
      r_haz_cnt <= r_haz_cnt - 2'd1;
    end
  end

  // Saturating count of accepted illegal instructions; survives flush.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_illegal_cnt <= 8'd0;
    end else if (w_push && w_dec.illegal && (r_illegal_cnt != 8'hFF)) begin
      r_illegal_cnt <= r_illegal_cnt + 8'd1;
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign bus.q_in_ready    = w_ready;
  assign bus.q_out_valid   = (r_count != '0);
  assign bus.q_op          = w_head.op;
  assign bus.q_seld        = w_head.seld;
  assign bus.q_sela        = w_head.sela;
  assign bus.q_imm         = w_head.imm;
  assign bus.q_simm        = w_head.simm;
  assign bus.q_reg_we      = w_head.reg_we;
  assign bus.q_sr_we       = w_head.sr_we;
  assign bus.q_req_alu     = w_head.req_alu;
  assign bus.q_req_ram     = w_head.req_ram;
  assign bus.q_req_ram_we  = w_head.req_ram_we;
  assign bus.q_illegal     = w_head.illegal;
  assign bus.q_illegal_cnt = r_illegal_cnt;

endmodule

// File: doc/prco_decode_stage.md
# prco_decode_stage

Parametrised, buffered instruction decode stage for the PRCO core. It accepts 16-bit instructions from fetch over a valid/ready handshake and decodes opcode, register selects and immediates into per-instruction control bundles. Bundles queue in a DEPTH-entry FIFO for the execute stage. It adds configurable load-use interlocking, flush, immediate extension to DATA_W, and illegal-opcode reporting. It sits between fetch and the ALU/RAM issue logic and replaces the single-register decoder.

## Interface
- DATA_W, 16: width of extended immediates q_imm / q_simm (≥8).
- DEPTH, 2: output FIFO entries; power of two, ≥2.
- HAZ_BUBBLES, 1: cycles a dependent instruction is held after an LW is accepted (0..3; 0 disables the interlock).

- i_clk  in  1  clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous flush of FIFO and hazard state.
- i_in_valid  in  1  i_instr is valid.
- i_instr  in  16  instruction: op[15:11], seld[10:8], sela[7:5], imm8[7:0], simm5[4:0].
- q_in_ready  out  1  stage accepts i_instr this cycle.
- q_out_valid  out  1  FIFO head is valid.
- i_out_ready  in  1  execute consumes the head this cycle.
- q_op  out  5  head opcode.
- q_seld, q_sela  out  3 each  head register selects.
- q_imm  out  DATA_W  imm8, zero-extended.
- q_simm  out  DATA_W  simm5, sign-extended.
- q_reg_we, q_sr_we, q_req_alu, q_req_ram, q_req_ram_we  out  1 each  head control bits.
- q_illegal  out  1  head opcode is not defined in the ISA include.
- q_illegal_cnt  out  8  saturating count of accepted illegal instructions.

## Operation
- Accept = i_in_valid & q_in_ready.
- q_in_ready = !i_reset & !i_flush & (count < DEPTH) & !hold.
- There is no push-through when full. A pop at full frees a slot for the next cycle only.
- On accept, the decoded bundle is written at the FIFO tail. The head drives the q_* fields directly from the storage registers.
- Pop = q_out_valid & i_out_ready.
- Control bits per `PRCO_OP_*`:
  - NOP: all control bits 0, entry still queued.
  - MOVI, MOV, ADD, ADDI, OR, XOR, AND: reg_we=1, req_alu=1.
  - CMP: sr_we=1, req_alu=1, reg_we=0.
  - LW: reg_we=1, req_alu=1, req_ram=1.
  - SW: req_alu=1, req_ram=1, req_ram_we=1.
  - Undefined opcode: illegal=1, all other control bits 0, fields still captured.
- Source registers read:
  - ADD, OR, XOR, AND, CMP, SW: seld and sela.
  - ADDI: seld.
  - MOV, LW: sela.
  - MOVI, NOP, illegal: none.
- Hazard tracking:
  - Accepting an LW loads haz_reg=seld and haz_cnt=HAZ_BUBBLES.
  - haz_cnt decrements each cycle while non-zero, whether or not the stage is stalled.
- hold = (haz_cnt ≠ 0) & i_in_valid & (presented instruction reads haz_reg).
- Non-dependent instructions are accepted during the count.
- Accepting a new LW reloads the tracker.
- Flush (i_flush=1):
  - Next edge: count=0, haz_cnt=0, pointers reset.
  - q_illegal_cnt is kept.
  - The input on the flush cycle is not accepted.
  - Pop on the flush cycle is ignored; the head is discarded.
- q_illegal_cnt increments on accept of an illegal opcode and saturates at 255.
- Reset: count, pointers, haz_cnt and q_illegal_cnt all cleared.

## Timing
- Reset values:
  - q_out_valid=0, q_in_ready=0.
  - All q_* fields, control bits and q_illegal_cnt = 0.
  - FIFO storage is cleared, so the head reads 0.
- q_in_ready rises combinationally once i_reset falls, since count=0.
- Latency: instruction accepted at edge N appears at head with q_out_valid=1 from edge N until popped. This is 1 cycle when the FIFO was empty.
- Throughput: 1 instruction/cycle with i_out_ready=1 and no hazards.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, ordering preserved.
- Pointers wrap modulo DEPTH.
- Head fields are held stable while q_out_valid=1 and i_out_ready=0.
- Interlock, HAZ_BUBBLES=1:
  - LW accepted at edge N; dependent instruction presented in the following cycle.
  - It has q_in_ready=0 in that cycle and is accepted at edge N+2.
- Reset asserted mid-operation clears all state immediately (asynchronous). Buffered entries are lost.

## Test plan
- After reset, push MOVI r1,0x2A (seld=1, imm8=0x2A) with i_out_ready=1 -> one cycle later: q_out_valid=1, q_seld=1, q_imm=0x002A, q_reg_we=1, q_req_alu=1.
- LW r2,-1(r3) (simm5=0x1F) -> q_simm=0xFFFF, req_ram=1, req_ram_we=0. Then ADD r4,r2 presented back-to-back -> q_in_ready=0 for exactly 1 cycle (HAZ_BUBBLES=1). A non-dependent MOVI r5 in the same slot is accepted without stall.
- i_out_ready=0, push 3 instructions at DEPTH=2 -> q_in_ready=0 after 2 accepts. Release i_out_ready -> order preserved, the third is accepted after the first pop, pointers wrap correctly.
- Undefined opcode 0x1F pushed 300 times -> each head has q_illegal=1 and all control bits 0. q_illegal_cnt stops at 255.
- FIFO holding 2 entries plus a pending LW hazard, pulse i_flush -> next cycle q_out_valid=0, count 0, dependent instruction accepted immediately.
- Assert i_reset mid-stream, between clock edges -> q_out_valid and all outputs 0 immediately, with no wait for a clock edge.
